// File: rtl/flip_board_seq.sv
// Full-board flip mask sequencer: issues row, column, diagonal and anti-diagonal
// lines to a shared flip8 unit and scatters the returned line flips onto the board.
module flip_board_seq #(
   parameter int FLIP8_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] player,
   input  logic [63:0] opponent,
   input  logic [5:0]  pos,
   output logic [7:0]  f8_player,
   output logic [7:0]  f8_opponent,
   output logic [2:0]  f8_pos,
   input  logic [7:0]  f8_flip,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] flip,
   output logic [6:0]  flip_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t      state_reg, state_next;
   logic [63:0] player_reg, opponent_reg, acc_reg, flip_reg, scatter;
   logic [5:0]  pos_reg;
   logic [1:0]  line_reg;
   logic        res_valid_reg;
   logic [6:0]  count_reg;
   logic        accept, issuing, occupied;
   logic        ret_valid;
   logic [1:0]  ret_line;
   logic [6:0]  issue_map [8];
   logic [6:0]  ret_map [8];

   // Maps lane i of line ln through the move square to {on_board, row, col}.
   function automatic logic [6:0] lane_map(input logic [1:0] ln, input logic [5:0] p, input int i);
      int r, c, rr, cc;
      r  = int'(p[5:3]);
      c  = int'(p[2:0]);
      rr = i;
      cc = i;
      case (ln)
         2'd0:    begin rr = r; cc = i;         end
         2'd1:    begin rr = i; cc = c;         end
         2'd2:    begin rr = i; cc = i - r + c; end
         default: begin rr = i; cc = r + c - i; end
      endcase
      lane_map = {(cc >= 0) && (cc < 8), rr[2:0], cc[2:0]};
   endfunction

   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
      return n;
   endfunction

   assign req_ready  = (state_reg == IDLE);
   assign accept     = req_valid && req_ready;
   assign issuing    = (state_reg == ISSUE);
   assign occupied   = player_reg[pos_reg] | opponent_reg[pos_reg];
   assign res_valid  = res_valid_reg;
   assign flip       = flip_reg;
   assign flip_count = count_reg;
   assign f8_pos     = !issuing ? 3'd0 : ((line_reg == 2'd0) ? pos_reg[2:0] : pos_reg[5:3]);

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign issue_map[gi]   = lane_map(line_reg, pos_reg, gi);
         assign ret_map[gi]     = lane_map(ret_line, pos_reg, gi);
         assign f8_player[gi]   = issuing && issue_map[gi][6] && player_reg[issue_map[gi][5:0]];
         assign f8_opponent[gi] = issuing && issue_map[gi][6] && opponent_reg[issue_map[gi][5:0]];
      end
   endgenerate

   // Tag pipe: tells which line each f8_flip return belongs to.
   generate
      if (FLIP8_LAT == 0) begin : g_lat0
         assign ret_valid = issuing;
         assign ret_line  = line_reg;
      end else begin : g_pipe
         logic       tv_reg [FLIP8_LAT];
         logic [1:0] tl_reg [FLIP8_LAT];
         always_ff @(posedge clock) begin
            if (reset) tv_reg[0] <= 1'b0;
            else       tv_reg[0] <= issuing;
            tl_reg[0] <= line_reg;
         end
         for (genvar gi = 1; gi < FLIP8_LAT; gi++) begin : g_stage
            always_ff @(posedge clock) begin
               if (reset) tv_reg[gi] <= 1'b0;
               else       tv_reg[gi] <= tv_reg[gi-1];
               tl_reg[gi] <= tl_reg[gi-1];
            end
         end
         assign ret_valid = tv_reg[FLIP8_LAT-1];
         assign ret_line  = tl_reg[FLIP8_LAT-1];
      end
   endgenerate

   // Off-board lanes are dropped here even if the flip8 unit reports bits for them.
   always_comb begin
      scatter = '0;
      for (int i = 0; i < 8; i++)
         if (ret_map[i][6] && f8_flip[i]) scatter[ret_map[i][5:0]] = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (accept) state_next = ISSUE;
         ISSUE: if (line_reg == 2'd3) state_next = (FLIP8_LAT == 0) ? DONE : DRAIN;
         DRAIN: if (ret_valid && ret_line == 2'd3) state_next = DONE;
         DONE:  if (res_valid_reg && res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         player_reg    <= '0;
         opponent_reg  <= '0;
         pos_reg       <= '0;
         line_reg      <= '0;
         acc_reg       <= '0;
         res_valid_reg <= 1'b0;
         flip_reg      <= '0;
         count_reg     <= '0;
      end else begin
         if (accept) begin
            player_reg   <= player;
            opponent_reg <= opponent;
            pos_reg      <= pos;
            line_reg     <= '0;
            acc_reg      <= '0;
         end else if (ret_valid) begin
            acc_reg <= acc_reg | scatter;
         end
         if (issuing) line_reg <= line_reg + 2'd1;
         // First DONE cycle registers the result; an occupied square yields no flips.
         if (state_reg == DONE && !res_valid_reg) begin
            res_valid_reg <= 1'b1;
            flip_reg      <= occupied ? '0 : acc_reg;
            count_reg     <= occupied ? '0 : popcount(acc_reg);
         end else if (res_valid_reg && res_ready) begin
            res_valid_reg <= 1'b0;
         end
      end
   end

endmodule
